// File: rtl/reset_sequencer.sv
// Reset release sequencer: qualifies PLL lock, board button and software request,
// then releases NUM_OUT active-low resets in order. Optional: RESET_SEQUENCER_LOCK_LOSS_CNT_EN.
module reset_sequencer #(
  parameter int unsigned NUM_OUT        = 3,
  parameter int unsigned STRETCH_CYCLES = 1024,
  parameter int unsigned STAGE_GAP      = 64
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               pll_locked,
  input  logic               ext_rst,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               sys_ready,
  output logic [1:0]         state_o
`ifdef RESET_SEQUENCER_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0]         lock_loss_cnt
`endif
);

  localparam int unsigned SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam int unsigned GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int unsigned IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       stretch_q, stretch_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_OUT-1:0]  rst_d;
  logic                ready_d;
  logic [1:0]          lock_sync, ext_sync;
  logic                lock_s, ext_s, clean;
`ifdef RESET_SEQUENCER_LOCK_LOSS_CNT_EN
  logic [7:0]          llc_d;
`endif

  // Two-flop synchronizers for the asynchronous qualifiers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_sync <= '0;
      ext_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
      ext_sync  <= {ext_sync[0], ext_rst};
    end
  end

  assign lock_s  = lock_sync[1];
  assign ext_s   = ext_sync[1];
  assign clean   = lock_s & ~ext_s & ~sw_rst_req;
  assign state_o = state_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_HOLD;
      stretch_q <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      rst_n_out <= '0;
      sys_ready <= 1'b0;
`ifdef RESET_SEQUENCER_LOCK_LOSS_CNT_EN
      lock_loss_cnt <= '0;
`endif
    end else begin
      state_q   <= state_d;
      stretch_q <= stretch_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      rst_n_out <= rst_d;
      sys_ready <= ready_d;
`ifdef RESET_SEQUENCER_LOCK_LOSS_CNT_EN
      lock_loss_cnt <= llc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    stretch_d = stretch_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    rst_d     = rst_n_out;
    ready_d   = sys_ready;
`ifdef RESET_SEQUENCER_LOCK_LOSS_CNT_EN
    llc_d     = lock_loss_cnt;
`endif

    case (state_q)
      ST_HOLD: begin
        rst_d   = '0;
        ready_d = 1'b0;
        gap_d   = '0;
        idx_d   = '0;
        if (!clean) begin
          stretch_d = '0;
        end else if (stretch_q == STRETCH_LAST) begin
          stretch_d = '0;
          state_d   = ST_RELEASE;
        end else begin
          stretch_d = stretch_q + 1'b1;
        end
      end

      ST_RELEASE, ST_RUN: begin
        if (!clean) begin
          // Abort: drop every channel together, never staged
          state_d   = ST_HOLD;
          stretch_d = '0;
          gap_d     = '0;
          idx_d     = '0;
          rst_d     = '0;
          ready_d   = 1'b0;
`ifdef RESET_SEQUENCER_LOCK_LOSS_CNT_EN
          if (!lock_s && lock_loss_cnt != 8'hFF) llc_d = lock_loss_cnt + 8'd1;
`endif
        end else if (state_q == ST_RELEASE) begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            rst_d = rst_n_out | (NUM_OUT'(1) << idx_q);
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_HOLD;
        rst_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

endmodule
